// File: rtl/wav_display_mc.sv
// Multi-channel waveform overlay: draws NCH sample traces as connected vertical
// segments inside a fixed plot window on a pass-through video stream (3-pclk latency).
module wav_display_mc #(
  parameter int NCH    = 2,
  parameter int DW     = 8,
  parameter int AW     = 10,
  parameter int WIN_X0 = 442,
  parameter int WIN_X1 = 1522,
  parameter int WIN_Y0 = 9,
  parameter int WIN_Y1 = 1075,
  parameter int CTR_Y  = 533
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                i_hs,
  input  logic                i_vs,
  input  logic                i_de,
  input  logic [23:0]         i_data,
  input  logic [NCH-1:0]      ch_en,
  input  logic [NCH*24-1:0]   ch_color,
  input  logic [NCH*4-1:0]    ch_scale,
  input  logic [NCH*12-1:0]   ch_offset,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [NCH*DW-1:0]   rd_data,
  output logic                o_hs,
  output logic                o_vs,
  output logic                o_de,
  output logic [23:0]         o_data,
  output logic                frame_done
);

  localparam int CW = 12;
  // Wide enough that a 7-bit magnify plus offset can never wrap before saturation.
  localparam int SW = DW + 24;
  localparam logic signed [SW-1:0] MID = SW'(2 ** (DW - 1));
  localparam logic signed [SW-1:0] CTR = SW'(CTR_Y);
  localparam logic signed [SW-1:0] YLO = SW'(WIN_Y0);
  localparam logic signed [SW-1:0] YHI = SW'(WIN_Y1);

  // S0: raster counters
  logic [CW-1:0] x_reg, y_reg;
  logic          de_prev_reg, vs_prev_reg, synced_reg;
  logic          vs_rise, de_fall, in_win, fd0;

  assign vs_rise = i_vs & ~vs_prev_reg;
  assign de_fall = de_prev_reg & ~i_de;
  assign in_win  = i_de && (x_reg >= CW'(WIN_X0)) && (x_reg <= CW'(WIN_X1)) &&
                   (y_reg >= CW'(WIN_Y0)) && (y_reg <= CW'(WIN_Y1));
  // Only a frame that started after reset may report completion.
  assign fd0     = in_win && (x_reg == CW'(WIN_X1)) && (y_reg == CW'(WIN_Y1)) && synced_reg;
  assign rd_en   = in_win & ~rst;
  assign rd_addr = AW'(x_reg - CW'(WIN_X0));

  always_ff @(posedge pclk) begin
    if (rst) begin
      x_reg       <= '0;
      y_reg       <= '0;
      de_prev_reg <= 1'b0;
      vs_prev_reg <= 1'b0;
      synced_reg  <= 1'b0;
    end else begin
      de_prev_reg <= i_de;
      vs_prev_reg <= i_vs;
      if (i_de)
        x_reg <= x_reg + CW'(1);
      else if (de_fall)
        x_reg <= '0;
      if (vs_rise)
        y_reg <= '0;
      else if (de_fall)
        y_reg <= y_reg + CW'(1);
      if (vs_rise)
        synced_reg <= 1'b1;
      else if (fd0)
        synced_reg <= 1'b0;
    end
  end

  // S1 / S2 pipeline registers
  logic          hs1_reg, vs1_reg, de1_reg, win1_reg, fd1_reg;
  logic [23:0]   data1_reg;
  logic [CW-1:0] x1_reg, y1_reg;
  logic          hs2_reg, vs2_reg, de2_reg, win2_reg, fd2_reg;
  logic [23:0]   data2_reg;
  logic [CW-1:0] x2_reg, y2_reg;

  logic [NCH-1:0][CW-1:0] ysat;
  logic [NCH-1:0][CW-1:0] yk2_reg;
  logic [NCH-1:0][CW-1:0] prev_reg;
  logic [NCH-1:0]         hit;
  logic                   first2;
  logic [23:0]            pix_next;

  assign first2 = (x2_reg == CW'(WIN_X0));

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic signed [SW-1:0] d_s, sh_s, off_s, yc_s;
      logic [3:0]           sc;
      logic [CW-1:0]        pe, lo, hi;

      // Sample to screen row: centre, scale, offset, then clamp into the window.
      assign sc    = ch_scale[gi*4 +: 4];
      assign d_s   = $signed({{(SW-DW){1'b0}}, rd_data[gi*DW +: DW]}) - MID;
      assign sh_s  = sc[3] ? (d_s <<< sc[2:0]) : (d_s >>> sc[2:0]);
      assign off_s = $signed({{(SW-12){ch_offset[gi*12+11]}}, ch_offset[gi*12 +: 12]});
      assign yc_s  = CTR + off_s - sh_s;
      assign ysat[gi] = (yc_s < YLO) ? CW'(WIN_Y0) :
                        (yc_s > YHI) ? CW'(WIN_Y1) : yc_s[CW-1:0];

      // Segment spans previous and current row; first column collapses to a point.
      assign pe = first2 ? yk2_reg[gi] : prev_reg[gi];
      assign lo = (pe < yk2_reg[gi]) ? pe : yk2_reg[gi];
      assign hi = (pe < yk2_reg[gi]) ? yk2_reg[gi] : pe;
      assign hit[gi] = ch_en[gi] & win2_reg & (y2_reg >= lo) & (y2_reg <= hi);
    end
  endgenerate

  always_comb begin
    pix_next = data2_reg;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (hit[k])
        pix_next = ch_color[k*24 +: 24];
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hs1_reg    <= 1'b0;
      vs1_reg    <= 1'b0;
      de1_reg    <= 1'b0;
      win1_reg   <= 1'b0;
      fd1_reg    <= 1'b0;
      data1_reg  <= '0;
      x1_reg     <= '0;
      y1_reg     <= '0;
      hs2_reg    <= 1'b0;
      vs2_reg    <= 1'b0;
      de2_reg    <= 1'b0;
      win2_reg   <= 1'b0;
      fd2_reg    <= 1'b0;
      data2_reg  <= '0;
      x2_reg     <= '0;
      y2_reg     <= '0;
      yk2_reg    <= '0;
      prev_reg   <= '0;
      o_hs       <= 1'b0;
      o_vs       <= 1'b0;
      o_de       <= 1'b0;
      o_data     <= '0;
      frame_done <= 1'b0;
    end else begin
      hs1_reg    <= i_hs;
      vs1_reg    <= i_vs;
      de1_reg    <= i_de;
      win1_reg   <= in_win;
      fd1_reg    <= fd0;
      data1_reg  <= i_data;
      x1_reg     <= x_reg;
      y1_reg     <= y_reg;
      hs2_reg    <= hs1_reg;
      vs2_reg    <= vs1_reg;
      de2_reg    <= de1_reg;
      win2_reg   <= win1_reg;
      fd2_reg    <= fd1_reg;
      data2_reg  <= data1_reg;
      x2_reg     <= x1_reg;
      y2_reg     <= y1_reg;
      yk2_reg    <= ysat;
      if (win2_reg)
        prev_reg <= yk2_reg;
      o_hs       <= hs2_reg;
      o_vs       <= vs2_reg;
      o_de       <= de2_reg;
      o_data     <= pix_next;
      frame_done <= fd2_reg;
    end
  end

endmodule

// File: tb/tb_wav_display_mc.sv
// Directed bench for wav_display_mc on a shrunken raster/window so whole frames fit in a short run.
module tb_wav_display_mc;

  localparam int NCH = 2, DW = 8, AW = 4;
  localparam int X0 = 2, X1 = 9, Y0 = 1, Y1 = 12, CY = 6;
  localparam int H_ACT = 12, V_ACT = 14;
  localparam logic [23:0] RED = 24'hFF0000, GRN = 24'h00FF00;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
  logic [23:0]       i_data = '0;
  logic [NCH-1:0]    ch_en = '0;
  logic [NCH*24-1:0] ch_color = '0;
  logic [NCH*4-1:0]  ch_scale = '0;
  logic [NCH*12-1:0] ch_offset = '0;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [NCH*DW-1:0] rd_data = '0;
  logic              o_hs, o_vs, o_de, frame_done;
  logic [23:0]       o_data;

  wav_display_mc #(
    .NCH(NCH), .DW(DW), .AW(AW), .WIN_X0(X0), .WIN_X1(X1),
    .WIN_Y0(Y0), .WIN_Y1(Y1), .CTR_Y(CY)
  ) dut (
    .pclk(clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .ch_en(ch_en), .ch_color(ch_color), .ch_scale(ch_scale), .ch_offset(ch_offset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Sample RAM: one-cycle registered read
  logic [DW-1:0] mem0 [16];
  logic [DW-1:0] mem1 [16];
  always @(posedge clk)
    if (rd_en) rd_data <= {mem1[rd_addr], mem0[rd_addr]};

  // Output frame capture, indexed by the bench's own output-side raster counters
  logic [23:0] fb [V_ACT][H_ACT];
  int   ox = 0, oy = 0, fd_cnt = 0, fdx = -1, fdy = -1;
  logic ode_prev = 1'b0, ovs_prev = 1'b0;
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fdx    <= ox;
      fdy    <= oy;
    end
    if (o_de) begin
      if (ox < H_ACT && oy < V_ACT) fb[oy][ox] <= o_data;
      ox <= ox + 1;
    end else if (ode_prev) begin
      ox <= 0;
      oy <= oy + 1;
    end
    if (o_vs && !ovs_prev) oy <= 0;
    ode_prev <= o_de;
    ovs_prev <= o_vs;
  end

  int errors = 0, checks = 0;
  int fd_base;
  logic        chk_pass = 1'b0;
  logic [26:0] hist [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pat(input int c, input int r);
    return {8'(r), 8'(c), 8'hA5};
  endfunction

  task automatic drive(input logic hs, input logic vs, input logic de, input logic [23:0] d);
    @(negedge clk);
    if (chk_pass)
      chk("pass", {5'd0, o_hs, o_vs, o_de, o_data}, {5'd0, hist[2]});
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {hs, vs, de, d};
    i_hs = hs; i_vs = vs; i_de = de; i_data = d;
  endtask

  task automatic run_frame(input int rst_line);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0, 24'h0);
    for (int l = 0; l < V_ACT; l++) begin
      drive(1'b1, 1'b0, 1'b0, 24'h0);
      drive(1'b1, 1'b0, 1'b0, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      for (int c = 0; c < H_ACT; c++) begin
        drive(1'b0, 1'b0, 1'b1, pat(c, l));
        if (l == rst_line && (c == 4 || c == 5))
          chk("rst_mid_out", {26'd0, rd_en, o_hs, o_vs, o_de, frame_done} | {8'd0, o_data}, 32'd0);
        if (l == rst_line && c == 3) rst = 1'b1;
        if (l == rst_line && c == 5) rst = 1'b0;
      end
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic check_fd(input string tag, input int exp_cnt);
    chk(tag, 32'(fd_cnt - fd_base), 32'(exp_cnt));
    if (exp_cnt == 1) begin
      chk("fd_x", 32'(fdx), 32'(X1));
      chk("fd_y", 32'(fdy), 32'(Y1));
    end
  endtask

  int lo_t [8] = '{6, 4, 4, 6, 3, 3, 6, 6};
  int hi_t [8] = '{6, 6, 8, 8, 6, 10, 10, 6};

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '0;
    for (int a = 0; a < 16; a++) begin
      mem0[a] = 8'd128;
      mem1[a] = 8'd128;
    end
    ch_color = {GRN, RED};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctl", {27'd0, rd_en, o_hs, o_vs, o_de, frame_done}, 32'd0);
    chk("reset_data", {8'd0, o_data}, 32'd0);
    rst = 1'b0;

    // 1: constant midscale -> single row at CTR_Y
    ch_en = 2'b01;
    fd_base = fd_cnt;
    run_frame(-1);
    for (int c = X0; c <= X1; c++) chk($sformatf("t1_r6_c%0d", c), {8'd0, fb[CY][c]}, {8'd0, RED});
    chk("t1_r5", {8'd0, fb[5][5]}, {8'd0, pat(5, 5)});
    chk("t1_r7", {8'd0, fb[7][5]}, {8'd0, pat(5, 7)});
    chk("t1_c1", {8'd0, fb[6][1]}, {8'd0, pat(1, 6)});
    chk("t1_c10", {8'd0, fb[6][10]}, {8'd0, pat(10, 6)});
    check_fd("t1_fd", 1);

    // 2: varying samples, >>5 -> connected vertical segments
    mem0[0] = 8'd128; mem0[1] = 8'd192; mem0[2] = 8'd64;  mem0[3] = 8'd128;
    mem0[4] = 8'd255; mem0[5] = 8'd0;   mem0[6] = 8'd128; mem0[7] = 8'd136;
    ch_scale = {4'h0, 4'b0101};
    run_frame(-1);
    for (int r = 0; r < V_ACT; r++)
      for (int c = X0; c <= X1; c++)
        chk($sformatf("t2_r%0d_c%0d", r, c), {8'd0, fb[r][c]},
            {8'd0, (r >= lo_t[c-X0] && r <= hi_t[c-X0]) ? RED : pat(c, r)});

    // 3: overlapping channels, priority then ch1 alone
    for (int a = 0; a < 16; a++) begin
      mem0[a] = 8'd200;
      mem1[a] = 8'd200;
    end
    ch_scale = {4'b0100, 4'b0100};
    ch_en = 2'b11;
    run_frame(-1);
    chk("t3_prio_c2", {8'd0, fb[2][2]}, {8'd0, RED});
    chk("t3_prio_c9", {8'd0, fb[2][9]}, {8'd0, RED});
    chk("t3_r3", {8'd0, fb[3][4]}, {8'd0, pat(4, 3)});
    ch_en = 2'b10;
    run_frame(-1);
    chk("t3_ch1_c2", {8'd0, fb[2][2]}, {8'd0, GRN});
    chk("t3_ch1_c7", {8'd0, fb[2][7]}, {8'd0, GRN});

    // 4: full-scale magnify with negative offset clamps to top window row
    for (int a = 0; a < 16; a++) mem0[a] = 8'd255;
    ch_en = 2'b01;
    ch_scale = {4'h0, 4'b1111};
    ch_offset = {12'd0, 12'hED4};
    run_frame(-1);
    for (int c = X0; c <= X1; c++) chk($sformatf("t4_r1_c%0d", c), {8'd0, fb[Y0][c]}, {8'd0, RED});
    chk("t4_r0", {8'd0, fb[0][5]}, {8'd0, pat(5, 0)});
    chk("t4_r12", {8'd0, fb[Y1][5]}, {8'd0, pat(5, Y1)});
    chk("t4_r11", {8'd0, fb[11][9]}, {8'd0, pat(9, 11)});

    // 5: nothing enabled -> exact 3-cycle passthrough
    ch_en = 2'b00;
    fd_base = fd_cnt;
    chk_pass = 1'b1;
    run_frame(-1);
    chk_pass = 1'b0;
    check_fd("t5_fd", 1);

    // 6: mid-frame reset, then a clean frame
    for (int a = 0; a < 16; a++) mem0[a] = 8'd128;
    ch_en = 2'b01;
    ch_scale = '0;
    ch_offset = '0;
    fd_base = fd_cnt;
    run_frame(5);
    check_fd("t6_partial_fd", 0);
    fd_base = fd_cnt;
    run_frame(-1);
    for (int c = X0; c <= X1; c += 3) chk($sformatf("t6_r6_c%0d", c), {8'd0, fb[CY][c]}, {8'd0, RED});
    chk("t6_r7", {8'd0, fb[7][4]}, {8'd0, pat(4, 7)});
    check_fd("t6_fd", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
